btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//  Synchronises and debounces one raw mechanical push-button input; first RTL stage behind the pin.
//  Produces a clean level plus one-cycle press / release / long-press strobes for control logic.
//  In simulation its input is driven by the bench bouncing-button model: ~1 us toggles, 10 us burst.
// PARAMETERS
//  DEBOUNCE_CYCLES  200     input must be stable this many clk cycles to be accepted (>=2)
//  LONG_CYCLES      100000  clk cycles of accepted hold before btn_long fires (>DEBOUNCE_CYCLES)
//  ACTIVE_LEVEL     1       raw level meaning "pressed" (1 = active-high, 0 = active-low)
//  REPEAT_CYCLES    25000   auto-repeat period after long press (only with BTN_DEBOUNCE_REPEAT_EN)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  synchronous reset, active low
//  btn_in       in   1  raw asynchronous button pin
//  btn_level    out  1  debounced state, 1 = pressed (polarity already normalised)
//  btn_press    out  1  one-cycle strobe on accepted press
//  btn_release  out  1  one-cycle strobe on accepted release
//  btn_long     out  1  one-cycle strobe when hold reaches LONG_CYCLES (auto-repeat strobes too, if enabled)
// BEHAVIOUR
//  - btn_in passes a 2-FF synchroniser; then XOR with ~ACTIVE_LEVEL gives s (1 = pressed).
//  - Sync FFs reset to the inactive level, so s = 0 out of reset.
//  - Reset: all outputs 0, FSM = REL, counters 0.
//  - One stability counter cnt, width $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES,REPEAT_CYCLES)+1).
//  - States and transitions:
//    REL     s=1 -> CHK_P, cnt=1
//    CHK_P   s=0 -> REL, cnt=0
//            cnt==DEBOUNCE_CYCLES-1 & s=1 -> PRS; btn_press=1 that cycle, btn_level<=1, cnt=0
//            else cnt++
//    PRS     s=0 -> CHK_R, cnt=1
//            else cnt++ (saturates at LONG_CYCLES)
//            cnt==LONG_CYCLES-1 -> btn_long=1, once per press
//    CHK_R   s=1 -> PRS (hold count lost, long already fired stays fired)
//            cnt==DEBOUNCE_CYCLES-1 & s=0 -> REL; btn_release=1, btn_level<=0
//  - Latency: press/release strobe is exactly 2+DEBOUNCE_CYCLES cycles after btn_in last changes.
//  - Any glitch shorter than DEBOUNCE_CYCLES never reaches outputs; each restarts the window.
//  - btn_press/btn_release/btn_long never assert together and never longer than 1 cycle.
//  - Reset mid-press clears everything. A button still held after reset is treated as a new press
//    (btn_press after debounce). No release strobe is emitted for the aborted press.
//  - Counter never wraps; saturation is explicit.
// CONFIGURATION
//  BTN_DEBOUNCE_REPEAT_EN defined:
//    - After btn_long, btn_long re-strobes every REPEAT_CYCLES while in PRS.
//    - The repeat phase restarts if CHK_R bounces back to PRS.
//  Undefined:
//    - btn_long fires at most once per press.
//    - REPEAT_CYCLES is unused and its logic is absent.
// TESTING (clk 100 MHz, DEBOUNCE_CYCLES=200, LONG_CYCLES=1000, REPEAT_CYCLES=300, ACTIVE_LEVEL=1)
//  1. Bouncing press: model set(1), 10 toggles at 1 us, stable at t0+10 us.
//     -> exactly one btn_press at t0+10 us+202 clk (+-1); btn_level=1; no strobe during the burst.
//  2. Bouncing release after 5 us hold -> exactly one btn_release 202 clk after stable 0;
//     btn_level=0; btn_long never fires.
//  3. 1 us isolated glitch while released (100 clk < 200) -> no outputs change.
//  4. Hold 20 us -> btn_long once at press+1000 clk.
//     With BTN_DEBOUNCE_REPEAT_EN: further strobes every 300 clk until release.
//     Without it: none.
//  5. rst_n low 3 clk while held, then high -> outputs 0 during reset;
//     btn_press 202 clk after rst_n rises; no btn_release.
//  6. ACTIVE_LEVEL=0 instance, input idle 1, pulse to 0 for 5 us -> press/release as in 1-2.

Source files
------------

// File: rtl/btn_debounce_if.sv
// Button debouncer signal bundle: raw pin in, clean level and event strobes out.
interface btn_debounce_if;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button synchroniser/debouncer with press, release and long-press strobes.
// Define BTN_DEBOUNCE_REPEAT_EN to make btn_long auto-repeat every REPEAT_CYCLES while held.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 200,
  parameter int unsigned LONG_CYCLES     = 100000,
  parameter bit          ACTIVE_LEVEL    = 1'b1,
  parameter int unsigned REPEAT_CYCLES   = 25000
) (
  input logic           clk,
  input logic           rst_n,
  btn_debounce_if.slave btn
);

  localparam int unsigned MaxDl     = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : LONG_CYCLES;
  localparam int unsigned MaxCycles = (REPEAT_CYCLES > MaxDl) ? REPEAT_CYCLES : MaxDl;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t DebLast  = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t LongLast = cnt_t'(LONG_CYCLES - 1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam cnt_t RepLast  = cnt_t'(REPEAT_CYCLES - 1);
  localparam cnt_t SatVal   = cnt_t'((REPEAT_CYCLES > LONG_CYCLES) ? REPEAT_CYCLES
                                                                   : LONG_CYCLES);
`else
  localparam cnt_t SatVal   = cnt_t'(LONG_CYCLES);
`endif

  typedef enum logic [1:0] {StRel, StChkP, StPrs, StChkR} state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   sync1_q, sync2_q;
  logic   level_q, level_d;
  logic   press_q, press_d;
  logic   release_q, release_d;
  logic   long_q, long_d;
  logic   long_done_q, long_done_d;
  logic   pressed;

  // Synchroniser idles at the inactive level so nothing looks pressed out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= ~ACTIVE_LEVEL;
      sync2_q <= ~ACTIVE_LEVEL;
    end else begin
      sync1_q <= btn.btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ ~ACTIVE_LEVEL;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRel;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      long_done_q <= long_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    unique case (state_q)
      StRel: begin
        if (pressed) begin
          state_d = StChkP;
          cnt_d   = cnt_t'(1);
        end
      end
      StChkP: begin
        if (!pressed) begin
          state_d = StRel;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d     = StPrs;
          press_d     = 1'b1;
          level_d     = 1'b1;
          cnt_d       = '0;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StPrs: begin
        if (!pressed) begin
          state_d = StChkR;
          cnt_d   = cnt_t'(1);
        end else if (!long_done_q && cnt_q == LongLast) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
`ifdef BTN_DEBOUNCE_REPEAT_EN
          cnt_d       = '0;
        end else if (long_done_q && cnt_q == RepLast) begin
          long_d = 1'b1;
          cnt_d  = '0;
`else
          cnt_d       = cnt_q + cnt_t'(1);
`endif
        end else if (cnt_q != SatVal) begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StChkR: begin
        // Bounce back: hold count restarts, but a fired long press is not re-armed.
        if (pressed) begin
          state_d = StPrs;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StRel;
          release_d = 1'b1;
          level_d   = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
    endcase
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;
  assign btn.btn_long    = long_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: bounce, glitch, long press, reset mid-press, active-low pin.
module tb_btn_debounce;

  localparam int unsigned Deb  = 200;
  localparam int unsigned Long = 1000;
  localparam int unsigned Rep  = 300;
  localparam int          Lat  = 202;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  btn_debounce_if bi ();
  btn_debounce_if bn ();

  btn_debounce #(
    .DEBOUNCE_CYCLES(Deb), .LONG_CYCLES(Long), .ACTIVE_LEVEL(1'b1), .REPEAT_CYCLES(Rep)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bi)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(Deb), .LONG_CYCLES(Long), .ACTIVE_LEVEL(1'b0), .REPEAT_CYCLES(Rep)
  ) u_dut_n (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_press = 0, n_rel = 0, n_long = 0, t_press = 0, t_rel = 0, t_long = 0;
  int n_press_n = 0, n_rel_n = 0, t_press_n = 0, t_rel_n = 0;
  int n_overlap = 0;
  int n_checks = 0, n_pass = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bi.btn_press === 1'b1) begin n_press++; t_press = cyc; end
    if (bi.btn_release === 1'b1) begin n_rel++; t_rel = cyc; end
    if (bi.btn_long === 1'b1) begin n_long++; t_long = cyc; end
    if (bn.btn_press === 1'b1) begin n_press_n++; t_press_n = cyc; end
    if (bn.btn_release === 1'b1) begin n_rel_n++; t_rel_n = cyc; end
    if (int'(bi.btn_press === 1'b1) + int'(bi.btn_release === 1'b1)
        + int'(bi.btn_long === 1'b1) > 1) n_overlap++;
    if (int'(bn.btn_press === 1'b1) + int'(bn.btn_release === 1'b1)
        + int'(bn.btn_long === 1'b1) > 1) n_overlap++;
  end

  task automatic bounce(input logic v);
    for (int i = 0; i < 10; i++) begin
      bi.btn_in = (i % 2 == 0) ? v : ~v;
      repeat (100) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bi.btn_in = 1'b0;
    bn.btn_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bi.btn_level !== 1'b0) $display("FAIL reset_level got %b want 0", bi.btn_level);
    else n_pass++;
    n_checks++;
    if (bi.btn_press !== 1'b0) $display("FAIL reset_press got %b want 0", bi.btn_press);
    else n_pass++;
    n_checks++;
    if (bi.btn_release !== 1'b0) $display("FAIL reset_release got %b want 0", bi.btn_release);
    else n_pass++;
    n_checks++;
    if (bi.btn_long !== 1'b0) $display("FAIL reset_long got %b want 0", bi.btn_long);
    else n_pass++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bounce_press();
    int p0, c0, w;
    p0 = n_press;
    bounce(1'b1);
    n_checks++;
    if (n_press != p0) $display("FAIL press_in_burst got %0d strobes want 0", n_press - p0);
    else n_pass++;
    bi.btn_in = 1'b1;
    c0 = cyc;
    w = 0;
    while (n_press == p0 && w < 400) begin @(negedge clk); w++; end
    n_checks++;
    if (t_press - c0 != Lat) $display("FAIL press_latency got %0d want %0d", t_press - c0, Lat);
    else n_pass++;
    n_checks++;
    if (bi.btn_level !== 1'b1) $display("FAIL press_level got %b want 1", bi.btn_level);
    else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_press != p0 + 1) $display("FAIL press_count got %0d want 1", n_press - p0);
    else n_pass++;
  endtask

  task automatic test_bounce_release();
    int r0, l0, c0, w;
    r0 = n_rel;
    l0 = n_long;
    repeat (480) @(negedge clk);
    bounce(1'b0);
    n_checks++;
    if (n_rel != r0) $display("FAIL release_in_burst got %0d strobes want 0", n_rel - r0);
    else n_pass++;
    bi.btn_in = 1'b0;
    c0 = cyc;
    w = 0;
    while (n_rel == r0 && w < 400) begin @(negedge clk); w++; end
    n_checks++;
    if (t_rel - c0 != Lat) $display("FAIL release_latency got %0d want %0d", t_rel - c0, Lat);
    else n_pass++;
    n_checks++;
    if (bi.btn_level !== 1'b0) $display("FAIL release_level got %b want 0", bi.btn_level);
    else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_rel != r0 + 1) $display("FAIL release_count got %0d want 1", n_rel - r0);
    else n_pass++;
    n_checks++;
    if (n_long != l0) $display("FAIL short_hold_long got %0d want 0", n_long - l0);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int p0, r0, l0;
    p0 = n_press;
    r0 = n_rel;
    l0 = n_long;
    repeat (50) @(negedge clk);
    bi.btn_in = 1'b1;
    repeat (100) @(negedge clk);
    bi.btn_in = 1'b0;
    repeat (300) @(negedge clk);
    n_checks++;
    if ((n_press - p0) + (n_rel - r0) + (n_long - l0) != 0)
      $display("FAIL glitch_strobes got %0d want 0", (n_press - p0) + (n_rel - r0) + (n_long - l0));
    else n_pass++;
    n_checks++;
    if (bi.btn_level !== 1'b0) $display("FAIL glitch_level got %b want 0", bi.btn_level);
    else n_pass++;
  endtask

  task automatic test_long();
    int p0, l0, r0, w, first, exp_n, exp_last;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    exp_n = 4;
    exp_last = Long + 3 * Rep;
`else
    exp_n = 1;
    exp_last = Long;
`endif
    p0 = n_press;
    l0 = n_long;
    r0 = n_rel;
    first = -1;
    bi.btn_in = 1'b1;
    w = 0;
    while (n_press == p0 && w < 400) begin @(negedge clk); w++; end
    while (cyc < t_press + 1950) begin
      @(negedge clk);
      if (n_long > l0 && first < 0) first = t_long;
    end
    bi.btn_in = 1'b0;
    w = 0;
    while (n_rel == r0 && w < 400) begin @(negedge clk); w++; end
    n_checks++;
    if (first - t_press != Long)
      $display("FAIL long_first got %0d want %0d", first - t_press, Long);
    else n_pass++;
    n_checks++;
    if (n_long - l0 != exp_n) $display("FAIL long_count got %0d want %0d", n_long - l0, exp_n);
    else n_pass++;
    n_checks++;
    if (t_long - t_press != exp_last)
      $display("FAIL long_last got %0d want %0d", t_long - t_press, exp_last);
    else n_pass++;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_held();
    int p0, r0, c0, w;
    p0 = n_press;
    bi.btn_in = 1'b1;
    w = 0;
    while (n_press == p0 && w < 400) begin @(negedge clk); w++; end
    repeat (50) @(negedge clk);
    r0 = n_rel;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long} !== 4'b0000)
      $display("FAIL held_reset_outputs got %b want 0000",
               {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long});
    else n_pass++;
    repeat (2) @(negedge clk);
    p0 = n_press;
    rst_n = 1'b1;
    c0 = cyc;
    w = 0;
    while (n_press == p0 && w < 400) begin @(negedge clk); w++; end
    n_checks++;
    if (t_press - c0 != Lat)
      $display("FAIL held_reset_press got %0d want %0d", t_press - c0, Lat);
    else n_pass++;
    n_checks++;
    if (n_rel != r0) $display("FAIL held_reset_release got %0d want 0", n_rel - r0);
    else n_pass++;
    bi.btn_in = 1'b0;
    w = 0;
    while (n_rel == r0 && w < 400) begin @(negedge clk); w++; end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_active_low();
    int p0, r0, c0, w;
    p0 = n_press_n;
    r0 = n_rel_n;
    bn.btn_in = 1'b0;
    c0 = cyc;
    w = 0;
    while (n_press_n == p0 && w < 400) begin @(negedge clk); w++; end
    n_checks++;
    if (t_press_n - c0 != Lat)
      $display("FAIL low_press_latency got %0d want %0d", t_press_n - c0, Lat);
    else n_pass++;
    n_checks++;
    if (bn.btn_level !== 1'b1) $display("FAIL low_level_held got %b want 1", bn.btn_level);
    else n_pass++;
    while (cyc < c0 + 500) @(negedge clk);
    bn.btn_in = 1'b1;
    c0 = cyc;
    w = 0;
    while (n_rel_n == r0 && w < 400) begin @(negedge clk); w++; end
    n_checks++;
    if (t_rel_n - c0 != Lat)
      $display("FAIL low_release_latency got %0d want %0d", t_rel_n - c0, Lat);
    else n_pass++;
    n_checks++;
    if (bn.btn_level !== 1'b0) $display("FAIL low_level_idle got %b want 0", bn.btn_level);
    else n_pass++;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (n_overlap != 0) $display("FAIL strobe_overlap got %0d want 0", n_overlap);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bounce_press();
    test_bounce_release();
    test_glitch();
    test_long();
    test_reset_held();
    test_active_low();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
